cv32e40p_trace_buffer: RTL and testbench

CV32E40P_TRACE_BUFFER -- requirements
Module: cv32e40p_trace_buffer

---
 rtl/cv32e40p_trace_buffer.sv | 200 ++++++++++++++++++++
 tb/tb_cv32e40p_trace_buffer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_trace_buffer.sv
// Trace buffer: per-hart retirement-record FIFOs merged onto one output
// stream by a round-robin arbiter. A full FIFO either back-pressures its
// hart (stall mode) or discards the record, counts the loss and marks the
// next stored record with a gap flag (drop mode).
//
// Handshake rule, used on every port pair: a transfer happens on a rising
// edge where valid and ready are both 1; valid never depends on ready, and
// a presented output record stays stable until it is taken.
module cv32e40p_trace_buffer #(
   parameter int unsigned NUM_CH    = 2,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned DROP_MODE = 0,
   parameter int unsigned CNT_W     = 16,
   localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    flush_i,
   input  logic [NUM_CH-1:0]       in_valid_i,
   output logic [NUM_CH-1:0]       in_ready_o,
   input  logic [NUM_CH*32-1:0]    in_pc_i,
   input  logic [NUM_CH*32-1:0]    in_instr_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [31:0]             out_pc_o,
   output logic [31:0]             out_instr_o,
   output logic [CH_W-1:0]         out_ch_o,
   output logic                    out_gap_o,
   output logic [NUM_CH*CNT_W-1:0] drop_cnt_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   // FIFO storage (not reset: occupancy decides what is meaningful)
   logic [31:0]      pc_mem_q    [NUM_CH][DEPTH];
   logic [31:0]      instr_mem_q [NUM_CH][DEPTH];
   logic             gap_mem_q   [NUM_CH][DEPTH];

   // FIFO control and per-channel bookkeeping
   logic [AW-1:0]    wptr_q      [NUM_CH];
   logic [AW-1:0]    rptr_q      [NUM_CH];
   logic [AW:0]      count_q     [NUM_CH];
   logic [CNT_W-1:0] drop_cnt_q  [NUM_CH];
   logic [NUM_CH-1:0] gap_pend_q;

   // Arbiter state
   logic [CH_W-1:0]  rr_ptr_q;
   logic [CH_W-1:0]  grant_q;
   logic             lock_q;

   logic [NUM_CH-1:0] full_w;
   logic [NUM_CH-1:0] empty_w;
   logic [NUM_CH-1:0] push_w;
   logic [NUM_CH-1:0] drop_w;
   logic [NUM_CH-1:0] pop_w;
   logic [CH_W-1:0]   arb_idx;
   logic [CH_W-1:0]   rr_grant;
   logic              rr_found;
   logic [CH_W-1:0]   grant_w;
   logic [CH_W-1:0]   rr_next;
   logic              out_valid_w;
   logic              hs_w;

   // Occupancy flags; full is the state at cycle start, independent of a same-cycle pop
   always_comb begin
      full_w  = '0;
      empty_w = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         full_w[c]  = (count_q[c] == (AW+1)'(DEPTH));
         empty_w[c] = (count_q[c] == '0);
      end
   end

   // Input acceptance: stall back-pressures, drop always accepts and discards when full
   always_comb begin
      in_ready_o = '0;
      push_w     = '0;
      drop_w     = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (DROP_MODE != 0) begin
            in_ready_o[c] = 1'b1;
            drop_w[c]     = in_valid_i[c] && full_w[c] && !flush_i;
         end else begin
            in_ready_o[c] = !full_w[c];
         end
         push_w[c] = in_valid_i[c] && !full_w[c] && !flush_i;
      end
   end

   // Round-robin search: first non-empty channel at or after rr_ptr, cyclically
   always_comb begin
      rr_found = 1'b0;
      rr_grant = '0;
      arb_idx  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         arb_idx = CH_W'((int'(rr_ptr_q) + i) % NUM_CH);
         if (!rr_found && !empty_w[arb_idx]) begin
            rr_found = 1'b1;
            rr_grant = arb_idx;
         end
      end
   end

   assign grant_w     = lock_q ? grant_q : rr_grant;
   assign out_valid_w = lock_q || (|(~empty_w));
   assign hs_w        = out_valid_w && out_ready_i;
   assign rr_next     = (grant_w == CH_W'(NUM_CH - 1)) ? '0 : grant_w + 1'b1;

   // Pop only the granted FIFO on a handshake; flush overrides it
   always_comb begin
      pop_w = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         pop_w[c] = hs_w && !flush_i && (grant_w == CH_W'(c));
      end
   end

   // Output record comes straight from the granted head; zero while idle
   always_comb begin
      out_valid_o = out_valid_w;
      out_pc_o    = '0;
      out_instr_o = '0;
      out_gap_o   = 1'b0;
      out_ch_o    = '0;
      if (out_valid_w) begin
         out_pc_o    = pc_mem_q[grant_w][rptr_q[grant_w]];
         out_instr_o = instr_mem_q[grant_w][rptr_q[grant_w]];
         out_gap_o   = gap_mem_q[grant_w][rptr_q[grant_w]];
         out_ch_o    = grant_w;
      end
   end

   // FIFO storage writes; the gap bit captures any loss since the last accepted record
   always_ff @(posedge clk_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
         if (push_w[c]) begin
            pc_mem_q[c][wptr_q[c]]    <= in_pc_i[c*32 +: 32];
            instr_mem_q[c][wptr_q[c]] <= in_instr_i[c*32 +: 32];
            gap_mem_q[c][wptr_q[c]]   <= gap_pend_q[c];
         end
      end
   end

   // FIFO pointers, occupancy, gap tracking and saturating drop counters
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         gap_pend_q <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            wptr_q[c]     <= '0;
            rptr_q[c]     <= '0;
            count_q[c]    <= '0;
            drop_cnt_q[c] <= '0;
         end
      end else if (flush_i) begin
         gap_pend_q <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            wptr_q[c]  <= '0;
            rptr_q[c]  <= '0;
            count_q[c] <= '0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (push_w[c]) wptr_q[c] <= wptr_q[c] + 1'b1;
            if (pop_w[c])  rptr_q[c] <= rptr_q[c] + 1'b1;
            case ({push_w[c], pop_w[c]})
               2'b10:   count_q[c] <= count_q[c] + 1'b1;
               2'b01:   count_q[c] <= count_q[c] - 1'b1;
               default: count_q[c] <= count_q[c];
            endcase
            if (drop_w[c]) begin
               gap_pend_q[c] <= 1'b1;
               if (drop_cnt_q[c] != {CNT_W{1'b1}}) drop_cnt_q[c] <= drop_cnt_q[c] + 1'b1;
            end else if (push_w[c]) begin
               gap_pend_q[c] <= 1'b0;
            end
         end
      end
   end

   // Arbiter state: hold the grant while the output is stalled, advance on handshake
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr_q <= '0;
         grant_q  <= '0;
         lock_q   <= 1'b0;
      end else if (flush_i) begin
         lock_q <= 1'b0;
      end else if (hs_w) begin
         rr_ptr_q <= rr_next;
         lock_q   <= 1'b0;
      end else if (out_valid_w) begin
         lock_q  <= 1'b1;
         grant_q <= grant_w;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt_out
      assign drop_cnt_o[g*CNT_W +: CNT_W] = drop_cnt_q[g];
   end

endmodule

// File: tb/tb_cv32e40p_trace_buffer.sv
// Bench for cv32e40p_trace_buffer: a stall-mode and a drop-mode (CNT_W=4)
// instance share one stimulus stream; each is compared every cycle against
// a queue-based reference model, plus directed scenario checks.
module tb_cv32e40p_trace_buffer;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        flush;
   logic [1:0]  in_valid;
   logic [63:0] in_pc;
   logic [63:0] in_instr;
   logic        out_ready;

   logic [1:0]  rdy_s, rdy_d;
   logic        ov_s, ov_d;
   logic [31:0] opc_s, opc_d, oin_s, oin_d;
   logic        och_s, och_d;
   logic        ogap_s, ogap_d;
   logic [31:0] dcnt_s;
   logic [7:0]  dcnt_d;

   cv32e40p_trace_buffer #(.NUM_CH(2), .DEPTH(4), .DROP_MODE(0), .CNT_W(16)) u_stall (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .in_valid_i(in_valid), .in_ready_o(rdy_s), .in_pc_i(in_pc), .in_instr_i(in_instr),
      .out_valid_o(ov_s), .out_ready_i(out_ready), .out_pc_o(opc_s), .out_instr_o(oin_s),
      .out_ch_o(och_s), .out_gap_o(ogap_s), .drop_cnt_o(dcnt_s)
   );

   cv32e40p_trace_buffer #(.NUM_CH(2), .DEPTH(4), .DROP_MODE(1), .CNT_W(4)) u_drop (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .in_valid_i(in_valid), .in_ready_o(rdy_d), .in_pc_i(in_pc), .in_instr_i(in_instr),
      .out_valid_o(ov_d), .out_ready_i(out_ready), .out_pc_o(opc_d), .out_instr_o(oin_d),
      .out_ch_o(och_d), .out_gap_o(ogap_d), .drop_cnt_o(dcnt_d)
   );

   // ---------------- scoreboard / reference model ----------------
   // index m*2+c: model m (0 stall, 1 drop), channel c; entry = {gap, instr, pc}
   logic [64:0] exp_q [4][$];
   bit          gp [4];
   int          dc [4];
   int          rr [2];
   bit          lk [2];
   int          lch [2];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Record the model presents: locked channel, else first non-empty from rr
   function automatic int exp_grant(input int m);
      if (lk[m]) return lch[m];
      for (int i = 0; i < 2; i++) begin
         int c = (rr[m] + i) % 2;
         if (exp_q[m*2+c].size() != 0) return c;
      end
      return -1;
   endfunction

   task automatic check_outputs(input int m);
      logic [1:0]  rdy;
      logic        ov, ch, gap;
      logic [31:0] pc, ins;
      logic [15:0] cnt [2];
      logic [64:0] rec;
      int g;
      if (m == 0) begin
         rdy = rdy_s; ov = ov_s; pc = opc_s; ins = oin_s; ch = och_s; gap = ogap_s;
         cnt[0] = dcnt_s[15:0]; cnt[1] = dcnt_s[31:16];
      end else begin
         rdy = rdy_d; ov = ov_d; pc = opc_d; ins = oin_d; ch = och_d; gap = ogap_d;
         cnt[0] = 16'(dcnt_d[3:0]); cnt[1] = 16'(dcnt_d[7:4]);
      end
      g = exp_grant(m);
      check($sformatf("m%0d out_valid", m), 64'(ov), 64'(g >= 0));
      for (int c = 0; c < 2; c++) begin
         check($sformatf("m%0d in_ready%0d", m, c), 64'(rdy[c]),
               64'((m == 1) || (exp_q[m*2+c].size() < 4)));
         check($sformatf("m%0d drop_cnt%0d", m, c), 64'(cnt[c]), 64'(dc[m*2+c]));
      end
      if (g >= 0) begin
         rec = exp_q[m*2+g][0];
         check($sformatf("m%0d out_ch", m), 64'(ch), 64'(g));
         check($sformatf("m%0d out_pc", m), 64'(pc), 64'(rec[31:0]));
         check($sformatf("m%0d out_instr", m), 64'(ins), 64'(rec[63:32]));
         check($sformatf("m%0d out_gap", m), 64'(gap), 64'(rec[64]));
      end
   endtask

   task automatic model_step(input int m);
      int g;
      bit hs;
      bit full [2];
      int cmax;
      cmax = (m == 0) ? 65535 : 15;
      if (rst) begin
         for (int c = 0; c < 2; c++) begin
            exp_q[m*2+c].delete(); gp[m*2+c] = 0; dc[m*2+c] = 0;
         end
         rr[m] = 0; lk[m] = 0;
         return;
      end
      if (flush) begin
         for (int c = 0; c < 2; c++) begin
            exp_q[m*2+c].delete(); gp[m*2+c] = 0;
         end
         lk[m] = 0;
         return;
      end
      g  = exp_grant(m);
      hs = (g >= 0) && out_ready;
      for (int c = 0; c < 2; c++) full[c] = (exp_q[m*2+c].size() == 4);
      if (hs) void'(exp_q[m*2+g].pop_front());
      for (int c = 0; c < 2; c++) begin
         if (in_valid[c]) begin
            if (!full[c]) begin
               exp_q[m*2+c].push_back({gp[m*2+c], in_instr[c*32 +: 32], in_pc[c*32 +: 32]});
               gp[m*2+c] = 0;
            end else if (m == 1) begin
               if (dc[m*2+c] < cmax) dc[m*2+c]++;
               gp[m*2+c] = 1;
            end
         end
      end
      if (hs) begin
         rr[m] = (g + 1) % 2; lk[m] = 0;
      end else if (g >= 0) begin
         lk[m] = 1; lch[m] = g;
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      #1;
      check_outputs(0);
      check_outputs(1);
      @(posedge clk);
      model_step(0);
      model_step(1);
      @(negedge clk);
   endtask

   task automatic drive(input logic [1:0] v, input logic rdy, input logic fl, input logic rs);
      in_valid  = v;
      out_ready = rdy;
      flush     = fl;
      rst       = rs;
      in_pc     = {$urandom, $urandom};
      in_instr  = {$urandom, $urandom};
      tick();
   endtask

   task automatic check_zero(input string tag);
      check({tag, " ov_s"}, 64'(ov_s), 64'd0);
      check({tag, " ov_d"}, 64'(ov_d), 64'd0);
      check({tag, " rdy_s"}, 64'(rdy_s), 64'd3);
      check({tag, " rdy_d"}, 64'(rdy_d), 64'd3);
      check({tag, " pc_s"}, 64'(opc_s), 64'd0);
      check({tag, " instr_s"}, 64'(oin_s), 64'd0);
      check({tag, " ch_s"}, 64'(och_s), 64'd0);
      check({tag, " gap_s"}, 64'(ogap_s), 64'd0);
      check({tag, " cnt_s"}, 64'(dcnt_s), 64'd0);
      check({tag, " cnt_d"}, 64'(dcnt_d), 64'd0);
   endtask

   // ---------------- stimulus ----------------
   logic [31:0] held_pc, held_instr;

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = '0; out_ready = 1'b0;
      in_pc = '0; in_instr = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_zero("por");

      // stall: 5 offers on ch0 with output blocked, then drain in order
      repeat (5) drive(2'b01, 1'b0, 1'b0, 1'b0);
      check("stall_full_ready", 64'(rdy_s[0]), 64'd0);
      check("drop_cnt0_after5", 64'(dcnt_d[3:0]), 64'd1);
      repeat (2) drive(2'b01, 1'b1, 1'b0, 1'b0);
      repeat (5) drive(2'b00, 1'b1, 1'b0, 1'b0);
      check("stall_drained", 64'(ov_s), 64'd0);
      check("stall_no_drops", 64'(dcnt_s), 64'd0);
      drive(2'b00, 1'b0, 1'b0, 1'b1);
      check_zero("rst1");

      // drop: 6 on ch1, drain, then gap marking on the next record only
      repeat (6) drive(2'b10, 1'b0, 1'b0, 1'b0);
      check("drop_cnt1_two", 64'(dcnt_d[7:4]), 64'd2);
      repeat (4) drive(2'b00, 1'b1, 1'b0, 1'b0);
      drive(2'b10, 1'b0, 1'b0, 1'b0);
      check("gap_valid", 64'(ov_d), 64'd1);
      check("gap_set", 64'(ogap_d), 64'd1);
      drive(2'b10, 1'b0, 1'b0, 1'b0);
      repeat (2) drive(2'b00, 1'b1, 1'b0, 1'b0);

      // flush with same-cycle push, handshake and would-be drop
      repeat (5) drive(2'b10, 1'b0, 1'b0, 1'b0);
      check("pre_flush_cnt1", 64'(dcnt_d[7:4]), 64'd3);
      drive(2'b11, 1'b1, 1'b1, 1'b0);
      check("flush_ov_s", 64'(ov_s), 64'd0);
      check("flush_ov_d", 64'(ov_d), 64'd0);
      check("flush_rdy_s", 64'(rdy_s), 64'd3);
      check("flush_cnt1_kept", 64'(dcnt_d[7:4]), 64'd3);
      repeat (2) drive(2'b10, 1'b1, 1'b0, 1'b0);
      repeat (2) drive(2'b01, 1'b0, 1'b0, 1'b0);
      drive(2'b01, 1'b0, 1'b0, 1'b1);
      check_zero("rst_mid");

      // round-robin alternation
      repeat (3) drive(2'b11, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("rr_seq%0d", i), 64'(och_s), 64'(i % 2));
         drive(2'b00, 1'b1, 1'b0, 1'b0);
      end
      check("rr_empty", 64'(ov_s), 64'd0);
      drive(2'b00, 1'b0, 1'b0, 1'b1);

      // lock: grant ch1 held while ch0 fills
      drive(2'b10, 1'b0, 1'b0, 1'b0);
      held_pc    = in_pc[63:32];
      held_instr = in_instr[63:32];
      for (int i = 0; i < 2; i++) begin
         drive((i == 0) ? 2'b01 : 2'b00, 1'b0, 1'b0, 1'b0);
         check("lock_ch", 64'(och_s), 64'd1);
         check("lock_pc", 64'(opc_s), 64'(held_pc));
         check("lock_instr", 64'(oin_s), 64'(held_instr));
      end
      drive(2'b00, 1'b1, 1'b0, 1'b0);
      check("lock_next_ch", 64'(och_s), 64'd0);
      drive(2'b00, 1'b0, 1'b0, 1'b1);

      // saturation of the 4-bit counter
      repeat (24) drive(2'b01, 1'b0, 1'b0, 1'b0);
      check("sat_cnt0", 64'(dcnt_d[3:0]), 64'd15);
      check("sat_stall_cnt", 64'(dcnt_s), 64'd0);
      drive(2'b00, 1'b0, 1'b0, 1'b1);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 99) == 0));
      end
      drive(2'b00, 1'b0, 1'b0, 1'b1);
      check_zero("final");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
